// File: rtl/fwd_stall_unit.sv
// Execute-stage operand forwarding across NSTAGE x NWR producers, load-use interlock,
// and a stall-time shadow buffer of writeback results; outputs are combinational, state is history/counter only.
module fwd_stall_unit #(
  parameter int XLEN   = 32,
  parameter int REGW   = 5,
  parameter int NSRC   = 2,
  parameter int NSTAGE = 4,
  parameter int NWR    = 2,
  parameter int HIST   = 2,
  parameter int CNTW   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          halt,
  input  logic                          src_valid,
  input  logic [NSRC*REGW-1:0]          src_id,
  input  logic [NSRC*XLEN-1:0]          src_regval,
  input  logic [NSTAGE-1:0]             stg_valid,
  input  logic [NSTAGE-1:0]             stg_is_load,
  input  logic [NSTAGE*NWR*REGW-1:0]    stg_tgt,
  input  logic [NSTAGE*NWR*XLEN-1:0]    stg_data,
  input  logic                          cnt_clr,
  output logic [NSRC*XLEN-1:0]          op_out,
  output logic                          stall,
  output logic [NSRC-1:0]               fwd_hit,
  output logic                          hist_ovf,
  output logic [CNTW-1:0]               stall_cnt
);

  logic [HIST-1:0][NWR-1:0][REGW-1:0] hist_tgt;
  logic [HIST-1:0][NWR-1:0][XLEN-1:0] hist_dat;
  logic [NWR-1:0][REGW-1:0]           wb_tgt;
  logic [NWR-1:0][XLEN-1:0]           wb_dat;
  logic [NSRC-1:0]                    load_win;

  // Writeback entries as they enter history; a bubble contributes no valid targets.
  always_comb begin
    for (int w = 0; w < NWR; w++) begin
      wb_tgt[w] = stg_valid[NSTAGE-1] ? stg_tgt[((NSTAGE-1)*NWR+w)*REGW +: REGW] : '0;
      wb_dat[w] = stg_data[((NSTAGE-1)*NWR+w)*XLEN +: XLEN];
    end
  end

  always_comb begin
    logic             found;
    logic [REGW-1:0]  id;
    op_out   = '0;
    fwd_hit  = '0;
    load_win = '0;
    for (int k = 0; k < NSRC; k++) begin
      id    = src_id[k*REGW +: REGW];
      found = 1'b0;
      op_out[k*XLEN +: XLEN] = src_regval[k*XLEN +: XLEN];
      if (id != '0) begin
        for (int s = 0; s < NSTAGE; s++) begin
          for (int w = 0; w < NWR; w++) begin
            if (!found && stg_valid[s] && stg_tgt[(s*NWR+w)*REGW +: REGW] == id) begin
              found                  = 1'b1;
              fwd_hit[k]             = 1'b1;
              op_out[k*XLEN +: XLEN] = stg_data[(s*NWR+w)*XLEN +: XLEN];
              // Only the winning producer can interlock; writeback data is already present.
              load_win[k]            = stg_is_load[s] && (s < NSTAGE-1);
            end
          end
        end
        for (int h = 0; h < HIST; h++) begin
          for (int w = 0; w < NWR; w++) begin
            if (!found && hist_tgt[h][w] == id) begin
              found                  = 1'b1;
              fwd_hit[k]             = 1'b1;
              op_out[k*XLEN +: XLEN] = hist_dat[h][w];
            end
          end
        end
      end
    end
    stall = src_valid && (|load_win);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_tgt  <= '0;
      hist_dat  <= '0;
      hist_ovf  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (!halt) begin
        if (stall) begin
          hist_tgt[0] <= wb_tgt;
          hist_dat[0] <= wb_dat;
          for (int k = 1; k < HIST; k++) begin
            hist_tgt[k] <= hist_tgt[k-1];
            hist_dat[k] <= hist_dat[k-1];
          end
          hist_ovf <= |hist_tgt[HIST-1];
        end else begin
          // Released: stale results must not shadow later register-file writes.
          hist_tgt <= '0;
          hist_ovf <= 1'b0;
        end
      end
      if (cnt_clr) begin
        stall_cnt <= '0;
      end else if (!halt && stall && stall_cnt != {CNTW{1'b1}}) begin
        stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Directed bench for fwd_stall_unit: forwarding priority, interlock, history shadowing,
// overflow, halt, counter saturation/clear and asynchronous reset mid-stall.
module tb_fwd_stall_unit;
  localparam int XLEN = 32, REGW = 5, NSRC = 2, NSTAGE = 4, NWR = 2, HIST = 2, CNTW = 4;

  logic                       clk = 1'b0;
  logic                       rst, halt, src_valid, cnt_clr;
  logic [NSRC*REGW-1:0]       src_id;
  logic [NSRC*XLEN-1:0]       src_regval;
  logic [NSTAGE-1:0]          stg_valid, stg_is_load;
  logic [NSTAGE*NWR*REGW-1:0] stg_tgt;
  logic [NSTAGE*NWR*XLEN-1:0] stg_data;
  logic [NSRC*XLEN-1:0]       op_out;
  logic                       stall, hist_ovf;
  logic [NSRC-1:0]            fwd_hit;
  logic [CNTW-1:0]            stall_cnt;

  int checks = 0;
  int errors = 0;

  fwd_stall_unit #(.XLEN(XLEN), .REGW(REGW), .NSRC(NSRC), .NSTAGE(NSTAGE),
                   .NWR(NWR), .HIST(HIST), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .halt(halt), .src_valid(src_valid), .src_id(src_id),
    .src_regval(src_regval), .stg_valid(stg_valid), .stg_is_load(stg_is_load),
    .stg_tgt(stg_tgt), .stg_data(stg_data), .cnt_clr(cnt_clr), .op_out(op_out),
    .stall(stall), .fwd_hit(fwd_hit), .hist_ovf(hist_ovf), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src_valid   = 1'b0;
    src_id      = '0;
    src_regval  = {32'h2222_2222, 32'h1111_1111};
    stg_valid   = '0;
    stg_is_load = '0;
    stg_tgt     = '0;
    stg_data    = '0;
    cnt_clr     = 1'b0;
  endtask

  task automatic set_wr(input int s, input int w, input logic [REGW-1:0] t, input logic [XLEN-1:0] d);
    stg_tgt[(s*NWR+w)*REGW +: REGW]  = t;
    stg_data[(s*NWR+w)*XLEN +: XLEN] = d;
    stg_valid[s] = 1'b1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  // Stage 0 load to r3 consumed by operand 0: a persistent interlock source.
  task automatic setup_stall(input logic [REGW-1:0] id1);
    clear_inputs();
    set_wr(0, 0, 5'd3, 32'hDEAD_0003);
    stg_is_load[0] = 1'b1;
    src_valid = 1'b1;
    src_id    = {id1, 5'd3};
  endtask

  task automatic test_reset();
    clear_inputs();
    halt = 1'b0;
    rst  = 1'b1;
    #3;
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
    checks++; if (hist_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", hist_ovf); end
    src_id = {5'd9, 5'd8};
    #1;
    checks++; if (op_out !== {32'h2222_2222, 32'h1111_1111} || fwd_hit !== 2'b00) begin
      errors++; $display("FAIL reset_regval got %h/%b exp 2222222211111111/00", op_out, fwd_hit); end
    rst = 1'b0;
  endtask

  task automatic test_priority();
    clear_inputs();
    halt = 1'b1;
    src_valid = 1'b1;
    set_wr(1, 1, 5'd5, 32'h11);
    set_wr(3, 0, 5'd5, 32'h22);
    src_id = {5'd9, 5'd5};
    #1;
    checks++; if (op_out[0 +: 32] !== 32'h11 || fwd_hit !== 2'b01 || stall !== 1'b0) begin
      errors++; $display("FAIL prio_stage got %h/%b/%b exp 11/01/0", op_out[0 +: 32], fwd_hit, stall); end
    checks++; if (op_out[32 +: 32] !== 32'h2222_2222) begin
      errors++; $display("FAIL prio_miss got %h exp 22222222", op_out[32 +: 32]); end
    stg_valid[1] = 1'b0;
    #1;
    checks++; if (op_out[0 +: 32] !== 32'h22) begin
      errors++; $display("FAIL prio_invalid got %h exp 22", op_out[0 +: 32]); end
    set_wr(2, 0, 5'd8, 32'h33);
    set_wr(2, 1, 5'd8, 32'h44);
    src_id = {5'd8, 5'd5};
    #1;
    checks++; if (op_out[32 +: 32] !== 32'h33 || fwd_hit !== 2'b11) begin
      errors++; $display("FAIL prio_port got %h/%b exp 33/11", op_out[32 +: 32], fwd_hit); end
  endtask

  task automatic test_load_use();
    setup_stall(5'd0);
    halt = 1'b1;
    src_id = {5'd3, 5'd0};
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_stall got %b exp 1", stall); end
    src_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_bubble got %b exp 0", stall); end
    src_valid = 1'b1;
    src_id = '0;
    #1;
    checks++; if (stall !== 1'b0 || op_out[32 +: 32] !== 32'h2222_2222 || fwd_hit !== 2'b00) begin
      errors++; $display("FAIL load_r0 got %b/%h/%b exp 0/22222222/00", stall, op_out[32 +: 32], fwd_hit); end
    clear_inputs();
    src_valid = 1'b1;
    set_wr(3, 1, 5'd3, 32'h77);
    stg_is_load[3] = 1'b1;
    src_id = {5'd3, 5'd0};
    #1;
    checks++; if (stall !== 1'b0 || op_out[32 +: 32] !== 32'h77) begin
      errors++; $display("FAIL load_wb got %b/%h exp 0/77", stall, op_out[32 +: 32]); end
    clear_inputs();
    src_valid = 1'b1;
    set_wr(2, 0, 5'd7, 32'h55);
    stg_is_load[2] = 1'b1;
    set_wr(1, 0, 5'd7, 32'h99);
    src_id = {5'd0, 5'd7};
    #1;
    checks++; if (stall !== 1'b0 || op_out[0 +: 32] !== 32'h99) begin
      errors++; $display("FAIL load_shadowed got %b/%h exp 0/99", stall, op_out[0 +: 32]); end
  endtask

  task automatic test_history_release();
    halt = 1'b0;
    pulse_reset();
    setup_stall(5'd1);
    set_wr(3, 0, 5'd4, 32'hAB);
    tick();
    set_wr(3, 0, 5'd6, 32'hCD);
    tick();
    checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL rel_cnt got %0d exp 2", stall_cnt); end
    clear_inputs();
    src_valid = 1'b1;
    src_id = {5'd6, 5'd4};
    #1;
    checks++; if (op_out !== {32'hCD, 32'hAB} || fwd_hit !== 2'b11 || stall !== 1'b0) begin
      errors++; $display("FAIL rel_hist got %h/%b/%b exp 000000cd000000ab/11/0", op_out, fwd_hit, stall); end
    tick();
    checks++; if (op_out !== {32'h2222_2222, 32'h1111_1111} || fwd_hit !== 2'b00) begin
      errors++; $display("FAIL rel_cleared got %h/%b exp 2222222211111111/00", op_out, fwd_hit); end
  endtask

  task automatic test_overflow_and_halt();
    pulse_reset();
    setup_stall(5'd1);
    set_wr(3, 0, 5'd4, 32'hAB);
    tick();
    tick();
    checks++; if (hist_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", hist_ovf); end
    tick();
    checks++; if (hist_ovf !== 1'b1 || stall_cnt !== 4'd3) begin
      errors++; $display("FAIL ovf_third got %b/%0d exp 1/3", hist_ovf, stall_cnt); end
    halt = 1'b1;
    repeat (5) tick();
    checks++; if (stall_cnt !== 4'd3 || hist_ovf !== 1'b1) begin
      errors++; $display("FAIL halt_hold got %0d/%b exp 3/1", stall_cnt, hist_ovf); end
    halt = 1'b0;
    cnt_clr = 1'b1;
    tick();
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL clr_priority got %0d exp 0", stall_cnt); end
    cnt_clr = 1'b0;
    src_valid = 1'b0;
    tick();
    checks++; if (hist_ovf !== 1'b0 || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL ovf_release got %b/%0d exp 0/0", hist_ovf, stall_cnt); end
  endtask

  task automatic test_saturation();
    pulse_reset();
    setup_stall(5'd0);
    repeat (15) tick();
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_max got %0d exp 15", stall_cnt); end
    repeat (2) tick();
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d exp 15", stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    pulse_reset();
    setup_stall(5'd4);
    set_wr(3, 0, 5'd4, 32'hAB);
    tick();
    stg_valid[3] = 1'b0;
    #1;
    checks++; if (op_out[32 +: 32] !== 32'hAB || fwd_hit[1] !== 1'b1 || stall_cnt !== 4'd1) begin
      errors++; $display("FAIL mid_pre got %h/%b/%0d exp ab/1/1", op_out[32 +: 32], fwd_hit[1], stall_cnt); end
    #1 rst = 1'b1;
    #1;
    checks++; if (op_out[32 +: 32] !== 32'h2222_2222 || fwd_hit[1] !== 1'b0) begin
      errors++; $display("FAIL mid_hist got %h/%b exp 22222222/0", op_out[32 +: 32], fwd_hit[1]); end
    checks++; if (stall_cnt !== 4'd0 || stall !== 1'b1) begin
      errors++; $display("FAIL mid_cnt_stall got %0d/%b exp 0/1", stall_cnt, stall); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_load_use();
    test_history_release();
    test_overflow_and_halt();
    test_saturation();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_stall_unit.md
Name: fwd_stall_unit

Overview:
- Parametrised operand-forwarding and load-use interlock unit for the execute stage.
- Generalises forwarding to NSTAGE downstream stages, each with NWR write ports, feeding NSRC source operands.
- Stalls only when the highest-priority producer of an operand is a load whose data is not yet available.
- Keeps a HIST-deep shadow buffer of writeback results captured during stalls; the buffer is cleared when the stall releases, so it never shadows later register-file writes.

Parameters:
XLEN, 32, datapath width
REGW, 5, register index width
NSRC, 2, source operands per instruction
NSTAGE, 4, downstream stages (0 = execute output, NSTAGE-1 = writeback)
NWR, 2, writes per stage
HIST, 2, stall shadow-buffer depth
CNTW, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
halt  in  1  freeze all sequential state
src_valid  in  1  consumer instruction is not a bubble
src_id  in  NSRC*REGW  source register indices, slot k at [k*REGW +: REGW]
src_regval  in  NSRC*XLEN  register-file read values
stg_valid  in  NSTAGE  stage holds a non-bubble instruction
stg_is_load  in  NSTAGE  stage instruction is a load
stg_tgt  in  NSTAGE*NWR*REGW  write targets, entry (s,w) at index s*NWR+w
stg_data  in  NSTAGE*NWR*XLEN  write data, same indexing as stg_tgt
cnt_clr  in  1  synchronous clear of stall_cnt
op_out  out  NSRC*XLEN  forwarded operands
stall  out  1  load-use interlock
fwd_hit  out  NSRC  operand k was taken from a stage or history entry
hist_ovf  out  1  one-cycle pulse when a live history entry is dropped
stall_cnt  out  CNTW  saturating count of stalled cycles

Behaviour:
- Reset values: all history targets and data = 0, stall_cnt = 0, hist_ovf = 0.
- op_out, stall and fwd_hit are combinational and depend on state only through the history buffer.
- Matching rules:
  - src_id = 0 never matches; it yields src_regval (the value 0 from the register file).
  - A stage entry matches only when stg_valid[s] = 1 and its tgt ≠ 0.
- Forwarding priority per operand:
  1. stages 0 → NSTAGE-1;
  2. within a stage, write port 0 → NWR-1;
  3. history entries 0 (youngest) → HIST-1;
  4. otherwise src_regval.
  - The first match supplies op_out and sets fwd_hit.
- Stall:
  - stall = src_valid && some operand's winning match is a stage entry with stg_is_load[s] = 1 and s < NSTAGE-1.
  - A load match in a stage is ignored when a younger stage also matches.
  - A load in the writeback stage never stalls.
- History update on posedge, when !halt:
  - If stall = 1: shift the buffer. hist[0] ← the NSTAGE-1 entries; a write port's tgt is forced to 0 if stg_valid[NSTAGE-1] = 0. hist[k] ← hist[k-1].
  - hist_ovf = 1 for that cycle iff hist[HIST-1] held any nonzero tgt.
  - If stall = 0: all history tgts ← 0 and hist_ovf ← 0.
- stall_cnt:
  - cnt_clr has priority and sets stall_cnt to 0.
  - Otherwise stall_cnt increments on each !halt cycle with stall = 1.
  - It saturates at 2^CNTW − 1.
- Halt: while halt = 1, history, hist_ovf and stall_cnt hold. Combinational outputs still track the inputs.
- Reset mid-stall: history is cleared immediately (asynchronously); a stall caused by the stage inputs persists.
- Sizing: an integration that must never lose a result sets HIST ≥ NSTAGE-1. hist_ovf is a debug flag only.

Test Plan:
- NSTAGE=4, NWR=2. Stage 1 writes r5=0x11 on port 1, stage 3 writes r5=0x22, src_id0 = 5 → op_out0 = 0x11, fwd_hit0 = 1, stall = 0.
- Stage 0 is a load to r3; src_id1 = 3; src_valid = 1 → stall = 1. Same inputs with src_valid = 0 → stall = 0. Same inputs with src_id1 = 0 → op_out1 = src_regval1, no stall.
- Stage 2 is a load r7, stage 1 is an ALU write r7 = 0x99, src_id0 = 7 → stall = 0, op_out0 = 0x99.
- Two-cycle stall while writeback retires r4 = 0xAB then r6 = 0xCD, then stall releases with src ids 4 and 6 and stages empty:
  - during the release cycle, op_out = 0xAB / 0xCD from history;
  - the next cycle, history is cleared and src_regval is used.
- HIST=2, three consecutive stall cycles with nonzero writeback targets → hist_ovf pulses on the third edge; stall_cnt = 3. Then cnt_clr → stall_cnt = 0.
- Async rst asserted mid-stall between clock edges → history tgts read 0 immediately, stall_cnt = 0. halt = 1 for 5 stalled cycles → stall_cnt unchanged.
